fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end: sequentially prefetches instruction words from the memory/icache port into a DEPTH-entry FIFO ahead of the decoder. Decoder pops from the FIFO head. Decoder-predicted redirects and ROB clears flush the queue and restart fetch. A stale response that is still in flight during a flush is discarded.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries; power of 2, >=2
RESET_PC, 0, fetch PC after reset

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global pause when low; all state frozen
mem_valid  out  1  fetch request pending
mem_addr  out  XLEN  fetch address; stable while mem_valid high and no mem_ready
mem_result  in  XLEN  fetched word; valid with mem_ready
mem_ready  in  1  one-cycle pulse completing the pending request
inst_valid  out  1  queue head valid
inst_addr  out  XLEN  PC of head entry
inst_result  out  XLEN  instruction word of head entry
dc_ok  in  1  decoder consumes head this cycle; ignored when inst_valid low
dc_redirect  in  1  with dc_ok: stream after head is wrong, refetch from dc_next_pc
dc_next_pc  in  XLEN  redirect target
rob_clear  in  1  misprediction flush, highest priority
rob_next_pc  in  XLEN  flush target
q_count  out  $clog2(DEPTH)+1  occupied entries, for debug/perf

Behaviour:
- Reset (async assert, sync deassert is the system's job):
  - fetch_pc=RESET_PC; head=tail=0; q_count=0; mem_valid=0; drop_pending=0.
  - inst_valid=0; inst_addr=0; inst_result=0.
- rdy_in low: no state changes; mem_ready and all other inputs are ignored that cycle.
- Storage: arrays addr[DEPTH] and data[DEPTH]; head/tail pointers of width $clog2(DEPTH), wrapping naturally; q_count tracks occupancy (0..DEPTH).
- Outputs: inst_valid = (q_count!=0); inst_addr/inst_result = entry[head]. Registered only; no mem-to-decoder bypass.
- Minimum latency: mem_ready at cycle N -> entry visible on inst_* at N+1.
- Request issue: mem_valid is registered. It asserts when q_count + (request outstanding) < DEPTH. It then holds with mem_addr=fetch_pc until mem_ready.
- On accepted mem_ready (drop_pending=0):
  - write {fetch_pc, mem_result} at tail; tail++; fetch_pc += 4 (mod 2^XLEN).
  - mem_valid may stay high next cycle if space remains, giving back-to-back fetch.
- Push and pop in the same cycle: q_count unchanged. Push is allowed at q_count==DEPTH-1 even with a simultaneous pop.
- Full: no request while the queue plus any outstanding request would exceed DEPTH; an overflowing write therefore cannot occur.
- Pop: dc_ok & inst_valid -> head++, q_count--.
- Redirect (dc_ok & inst_valid & dc_redirect, no rob_clear):
  - head entry is consumed; all remaining entries discarded (q_count=0, head=tail).
  - fetch_pc=dc_next_pc.
  - any same-cycle mem_ready data is discarded.
- rob_clear: same as redirect, but the head is not consumed (whole queue flushed), fetch_pc=rob_next_pc. Overrides dc_ok/dc_redirect in the same cycle.
- Stale-response handling on any flush:
  - If a request is outstanding and mem_ready is not high that cycle: set drop_pending=1. mem_valid stays high with the old mem_addr until the pending mem_ready arrives. That response is dropped, drop_pending clears, and the next cycle issues at the new fetch_pc.
  - If mem_ready coincides with the flush: drop that data, no drop_pending, issue the new fetch_pc next cycle.
- A second flush while drop_pending=1 only updates fetch_pc; one response is still dropped.
- fetch_pc, mem_addr and stored PCs are word addresses in bytes. Low 2 bits are passed through unchanged, with no alignment check.

Test Plan:
- Reset then memory responding 1 cycle after each request: mem_addr 0x0,0x4,0x8,0xC. With decoder idle, the queue fills to 4 and mem_valid drops. inst_addr=0x0, inst_result=first word.
- Decoder pops every cycle with a 1-cycle memory: steady one-instruction-per-cycle stream with addrs 0x0,0x4,...; q_count stays in 0..2; no duplicate or missing PC.
- Queue holding 0x10..0x1C, dc_ok+dc_redirect to 0x100: head 0x10 consumed, q_count=0 next cycle, next request addr 0x100, next inst_addr 0x100.
- rob_clear to 0x200 while a request for 0x20 is outstanding (mem_ready 3 cycles later):
  - queue empties; mem_addr holds 0x20 until mem_ready; that word never appears on inst_*.
  - the following request is 0x200.
- rob_clear and dc_ok+dc_redirect in the same cycle: rob_next_pc wins and the head is not counted as consumed.
- rdy_in low for 5 cycles mid-stream with mem_ready pulses during the pause: q_count, pointers and outputs unchanged. Stream resumes identically. Async rst_n_in low mid-fetch immediately forces mem_valid=0 and inst_valid=0.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_queue                                                     |
// | Brief    : Sequential instruction prefetcher feeding a DEPTH-entry FIFO    |
// |            ahead of the decoder, with redirect/flush and stale-drop logic. |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    output logic                    mem_valid,
    output logic [XLEN-1:0]         mem_addr,
    input  logic [XLEN-1:0]         mem_result,
    input  logic                    mem_ready,
    output logic                    inst_valid,
    output logic [XLEN-1:0]         inst_addr,
    output logic [XLEN-1:0]         inst_result,
    input  logic                    dc_ok,
    input  logic                    dc_redirect,
    input  logic [XLEN-1:0]         dc_next_pc,
    input  logic                    rob_clear,
    input  logic [XLEN-1:0]         rob_next_pc,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int              c_PW    = $clog2(DEPTH);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [XLEN-1:0] r_addr [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_mem_valid;
    logic            r_drop_pending;

    logic            w_accept;
    logic            w_pop_ok;
    logic            w_redirect;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic            w_still_out;
    logic            w_drop_nxt;
    logic            w_mem_valid_nxt;
    logic [c_CW-1:0] w_count_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;

    assign w_accept    = r_mem_valid & mem_ready;
    assign w_pop_ok    = dc_ok & inst_valid;
    assign w_redirect  = w_pop_ok & dc_redirect & ~rob_clear;
    assign w_flush     = rob_clear | w_redirect;
    assign w_pop       = w_pop_ok & ~rob_clear;
    // Responses are never written while a flush is in progress or a stale one is owed.
    assign w_push      = w_accept & ~r_drop_pending & ~w_flush;
    assign w_still_out = r_mem_valid & ~mem_ready;
    assign w_drop_nxt  = r_drop_pending ? ~w_accept : (w_flush & w_still_out);

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CW'(1);
        end

        w_fetch_pc_nxt = r_fetch_pc;
        if (rob_clear) begin
            w_fetch_pc_nxt = rob_next_pc;
        end else if (w_redirect) begin
            w_fetch_pc_nxt = dc_next_pc;
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end
    end

    // A live request is held until completed; a new one needs room for its result.
    assign w_mem_valid_nxt = w_still_out | (w_count_nxt < c_DEPTH);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_fetch_pc     <= RESET_PC;
            r_mem_addr     <= RESET_PC;
            r_mem_valid    <= 1'b0;
            r_drop_pending <= 1'b0;
        end else if (rdy_in) begin
            if (w_push) begin
                r_addr[r_tail] <= r_fetch_pc;
                r_data[r_tail] <= mem_result;
                r_tail         <= r_tail + c_PW'(1);
            end
            if (w_flush) begin
                r_head <= r_tail;
            end else if (w_pop) begin
                r_head <= r_head + c_PW'(1);
            end
            r_count        <= w_count_nxt;
            r_fetch_pc     <= w_fetch_pc_nxt;
            r_drop_pending <= w_drop_nxt;
            r_mem_valid    <= w_mem_valid_nxt;
            if (!w_still_out) begin
                r_mem_addr <= w_fetch_pc_nxt;
            end
        end
    end

    assign mem_valid   = r_mem_valid;
    assign mem_addr    = r_mem_addr;
    assign inst_valid  = (r_count != '0);
    assign inst_addr   = r_addr[r_head];
    assign inst_result = r_data[r_head];
    assign q_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_queue                                                  |
// | Brief    : Self-checking bench: program-order stream model plus scoreboard |
// |            of flush targets, directed corner cases and random traffic.     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_result;
    logic        mem_ready;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_result;
    logic        dc_ok;
    logic        dc_redirect;
    logic [31:0] dc_next_pc;
    logic        rob_clear;
    logic [31:0] rob_next_pc;
    logic [2:0]  q_count;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_result(mem_result),
        .mem_ready(mem_ready), .inst_valid(inst_valid), .inst_addr(inst_addr),
        .inst_result(inst_result), .dc_ok(dc_ok), .dc_redirect(dc_redirect),
        .dc_next_pc(dc_next_pc), .rob_clear(rob_clear), .rob_next_pc(rob_next_pc),
        .q_count(q_count)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          errors = 0;
    int          n_cons = 0;
    logic [31:0] tgt_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] exp_pc = RESET_PC;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_cnt = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory contents are a fixed hash of the byte address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'($urandom_range(1023)) << 2;
        if ($urandom_range(9) == 0) p = p | 32'($urandom_range(3));
        if ($urandom_range(19) == 0) p = 32'hFFFF_FFF0;
        return p;
    endfunction

    // Memory responder plus flush-target scoreboard push, then advance one clock.
    task automatic cycle();
        if (!rst_n_in) pend = 1'b0;
        mem_ready = 1'b0;
        if (rst_n_in && pend) chk("mem_valid_held", 32'(mem_valid), 32'd1);
        if (rst_n_in && mem_valid) begin
            if (!pend) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
                wait_cnt  = $urandom_range(lat_hi, lat_lo);
            end else begin
                chk("mem_addr_stable", mem_addr, pend_addr);
            end
            if (wait_cnt == 0) begin
                mem_ready  = 1'b1;
                mem_result = rdy_in ? word_of(pend_addr) : $urandom();
            end else begin
                wait_cnt--;
            end
        end
        if (rst_n_in && rdy_in) begin
            if (rob_clear) tgt_q.push_back(rob_next_pc);
            else if (dc_ok && dc_redirect && inst_valid) tgt_q.push_back(dc_next_pc);
        end
        @(posedge clk_in);
        #1;
        if (mem_ready && rdy_in && rst_n_in) begin
            pend = 1'b0;
            issued_q.push_back(pend_addr);
        end
        mem_ready = 1'b0;
    endtask

    task automatic wait_inst(input logic [31:0] exp_addr, input string nm);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            cycle();
            n++;
        end
        chk({nm, "_timeout"}, 32'(inst_valid), 32'd1);
        chk({nm, "_addr"}, inst_addr, exp_addr);
        chk({nm, "_result"}, inst_result, word_of(exp_addr));
    endtask

    // Monitor: the decoder must see an unbroken program-order stream between flushes.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            exp_pc = RESET_PC;
            tgt_q.delete();
        end else begin
            chk("q_count_range", (q_count <= 3'(DEPTH)) ? 32'd1 : 32'd0, 32'd1);
            chk("inst_valid_vs_count", 32'(inst_valid), (q_count != 3'd0) ? 32'd1 : 32'd0);
            if (rdy_in) begin
                if (rob_clear) begin
                    chk("tgt_available", (tgt_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                    if (tgt_q.size() != 0) exp_pc = tgt_q.pop_front();
                end else if (dc_ok && inst_valid) begin
                    chk("stream_addr", inst_addr, exp_pc);
                    chk("stream_result", inst_result, word_of(exp_pc));
                    n_cons++;
                    if (dc_redirect) begin
                        chk("tgt_available", (tgt_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                        if (tgt_q.size() != 0) exp_pc = tgt_q.pop_front();
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] s_cnt, s_addr, s_res, s_mv, s_ma;
        rst_n_in = 1'b0; rdy_in = 1'b1; mem_ready = 1'b0; mem_result = '0;
        dc_ok = 1'b0; dc_redirect = 1'b0; dc_next_pc = '0;
        rob_clear = 1'b0; rob_next_pc = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_inst_addr", inst_addr, 32'd0);
        chk("rst_inst_result", inst_result, 32'd0);
        rst_n_in = 1'b1;
        issued_q.delete();

        // Fill with decoder idle
        repeat (8) cycle();
        chk("fill_count", 32'(q_count), 32'd4);
        chk("fill_mem_valid", 32'(mem_valid), 32'd0);
        chk("fill_inst_addr", inst_addr, 32'h0);
        chk("fill_inst_result", inst_result, word_of(32'h0));
        chk("fill_issued", 32'(issued_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < issued_q.size(); i++)
            chk("fill_issue_addr", issued_q[i], 32'(i * 4));

        // Redirect from a full queue holding 0x10..0x1C
        rob_clear = 1'b1; rob_next_pc = 32'h10;
        cycle();
        rob_clear = 1'b0;
        repeat (8) cycle();
        chk("q10_count", 32'(q_count), 32'd4);
        chk("q10_head", inst_addr, 32'h10);
        dc_ok = 1'b1; dc_redirect = 1'b1; dc_next_pc = 32'h100;
        cycle();
        dc_ok = 1'b0; dc_redirect = 1'b0;
        chk("redir_count", 32'(q_count), 32'd0);
        chk("redir_mem_valid", 32'(mem_valid), 32'd1);
        chk("redir_mem_addr", mem_addr, 32'h100);
        cycle();
        chk("redir_inst_valid", 32'(inst_valid), 32'd1);
        chk("redir_inst_addr", inst_addr, 32'h100);
        repeat (8) cycle();

        // Flush while a slow request is outstanding
        lat_lo = 3; lat_hi = 3;
        rob_clear = 1'b1; rob_next_pc = 32'h20;
        cycle();
        chk("stale_req_addr", mem_addr, 32'h20);
        rob_next_pc = 32'h200;
        cycle();
        rob_clear = 1'b0;
        chk("stale_hold_addr", mem_addr, 32'h20);
        chk("stale_hold_valid", 32'(mem_valid), 32'd1);
        chk("stale_empty", 32'(inst_valid), 32'd0);
        repeat (3) cycle();
        lat_lo = 0; lat_hi = 0;
        chk("stale_new_addr", mem_addr, 32'h200);
        chk("stale_dropped", 32'(inst_valid), 32'd0);
        wait_inst(32'h200, "after_drop");

        // rob_clear beats a simultaneous redirect
        repeat (3) cycle();
        rob_clear = 1'b1; rob_next_pc = 32'h300;
        dc_ok = 1'b1; dc_redirect = 1'b1; dc_next_pc = 32'h400;
        cycle();
        rob_clear = 1'b0; dc_ok = 1'b0; dc_redirect = 1'b0;
        chk("prio_count", 32'(q_count), 32'd0);
        wait_inst(32'h300, "prio");

        // Pause mid-fill with mem_ready pulses and decoder requests
        rob_clear = 1'b1; rob_next_pc = 32'h500;
        cycle();
        rob_clear = 1'b0;
        repeat (2) cycle();
        s_cnt = 32'(q_count); s_addr = inst_addr; s_res = inst_result;
        s_mv = 32'(mem_valid); s_ma = mem_addr;
        rdy_in = 1'b0; dc_ok = 1'b1;
        repeat (5) begin
            cycle();
            chk("pause_count", 32'(q_count), s_cnt);
            chk("pause_inst_addr", inst_addr, s_addr);
            chk("pause_inst_result", inst_result, s_res);
            chk("pause_mem_valid", 32'(mem_valid), s_mv);
            chk("pause_mem_addr", mem_addr, s_ma);
        end
        rdy_in = 1'b1; dc_ok = 1'b0;
        repeat (8) cycle();
        chk("resume_count", 32'(q_count), 32'd4);
        chk("resume_head", inst_addr, 32'h500);

        // Asynchronous reset mid-fetch
        rob_clear = 1'b1; rob_next_pc = 32'h600;
        cycle();
        rob_clear = 1'b0;
        cycle();
        #1;
        rst_n_in = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_inst_valid", 32'(inst_valid), 32'd0);
        chk("arst_q_count", 32'(q_count), 32'd0);
        pend = 1'b0;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        repeat (3) cycle();
        chk("arst_restart_addr", inst_addr, RESET_PC);
        chk("arst_restart_valid", 32'(inst_valid), 32'd1);

        // Random traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            lat_lo      = 0;
            lat_hi      = (i < 1500) ? 0 : 3;
            rdy_in      = ($urandom_range(99) < 90);
            dc_ok       = ($urandom_range(99) < 60);
            dc_redirect = ($urandom_range(99) < 6);
            dc_next_pc  = rand_pc();
            rob_clear   = ($urandom_range(99) < 3);
            rob_next_pc = rand_pc();
            cycle();
        end
        rdy_in = 1'b1; dc_ok = 1'b0; dc_redirect = 1'b0; rob_clear = 1'b0;
        cycle();
        chk("stream_progress", (n_cons > 300) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
